// File: rtl/kf_choir_verdict.sv
// kf_choir_verdict
//   Consumes the ensemble choir's bit-serial consensus stream, packs result
//   bits LSB-first into WORD_W-bit words behind a small FIFO, and produces one
//   auto-act / escalate verdict per hypervector frame from confidence stats.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_bit/in_conf/in_last  consensus stream (no backpressure)
//   conf_thresh                   per-bit low-confidence threshold
//   mean_thresh, max_lowconf      verdict escalation thresholds
//   word_valid/ready/data/last    packed word FIFO head
//   verdict_valid/ready           verdict handshake
//   verdict_escalate/mean/min/lowconf/bits  verdict payload
//   overflow, clear_overflow      sticky drop indicator and its clear
//   busy                          frame in progress or verdict outstanding
module kf_choir_verdict #(
   parameter int HV_DIM     = 8192,
   parameter int WORD_W     = 64,
   parameter int CONF_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = $clog2(HV_DIM+1),
   parameter int SUM_W      = CONF_WIDTH + CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  in_bit,
   input  logic [CONF_WIDTH-1:0] in_conf,
   input  logic                  in_last,
   input  logic [CONF_WIDTH-1:0] conf_thresh,
   input  logic [CONF_WIDTH-1:0] mean_thresh,
   input  logic [CNT_W-1:0]      max_lowconf,
   output logic                  word_valid,
   input  logic                  word_ready,
   output logic [WORD_W-1:0]     word_data,
   output logic                  word_last,
   output logic                  verdict_valid,
   input  logic                  verdict_ready,
   output logic                  verdict_escalate,
   output logic [CONF_WIDTH-1:0] verdict_mean,
   output logic [CONF_WIDTH-1:0] verdict_min,
   output logic [CNT_W-1:0]      verdict_lowconf,
   output logic [CNT_W-1:0]      verdict_bits,
   output logic                  overflow,
   input  logic                  clear_overflow,
   output logic                  busy
);

   localparam int POS_W = $clog2(WORD_W);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int DIV_W = $clog2(CONF_WIDTH+1);
   localparam int DW    = SUM_W + CONF_WIDTH;

   // Stream side uses IDLE/ACCUM, verdict side uses IDLE/DIVIDE/VERDICT;
   // the two run independently so a new frame can start while dividing.
   typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, VERDICT} state_t;

   typedef struct packed {
      logic [SUM_W-1:0]      sum;
      logic [CNT_W-1:0]      cnt;
      logic [CONF_WIDTH-1:0] mn;
      logic [CNT_W-1:0]      low;
      logic                  flag;   // dropped word or truncated frame
      logic [CONF_WIDTH-1:0] mthr;
      logic [CNT_W-1:0]      mlow;
   } snap_t;

   // ---------------- stream side ----------------
   state_t                s_state, s_next;
   logic [POS_W-1:0]      pos;
   logic [WORD_W-1:0]     pack;
   logic [CNT_W-1:0]      bits_acc;
   logic [SUM_W-1:0]      sum_acc;
   logic [CONF_WIDTH-1:0] min_acc;
   logic [CNT_W-1:0]      low_acc;
   logic                  drop_acc;

   logic [CNT_W-1:0]      bits_nx, low_nx;
   logic [SUM_W-1:0]      sum_nx;
   logic [CONF_WIDTH-1:0] min_nx;
   logic [WORD_W-1:0]     word_nx;
   logic                  hit_max, close, trunc, push, low_bit;

   assign bits_nx = bits_acc + CNT_W'(1);
   assign hit_max = (bits_nx == CNT_W'(HV_DIM));
   assign close   = in_valid & (in_last | hit_max);
   assign trunc   = hit_max & ~in_last;
   assign low_bit = (in_conf < conf_thresh);
   assign low_nx  = low_acc + CNT_W'(low_bit);
   assign sum_nx  = sum_acc + SUM_W'(in_conf);
   assign min_nx  = (in_conf < min_acc) ? in_conf : min_acc;
   // pack is zeroed after every push, so bits above pos are already zero
   assign word_nx = pack | (WORD_W'(in_bit) << pos);
   assign push    = in_valid & ((pos == POS_W'(WORD_W-1)) | close);

   // ---------------- word FIFO ----------------
   logic [WORD_W:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   fcnt;
   logic             full, pop, wr_ok, drop;

   assign full       = (fcnt == (PTR_W+1)'(FIFO_DEPTH));
   assign word_valid = (fcnt != '0);
   assign pop        = word_valid & word_ready;
   // a pop in the same cycle frees the slot, so full+pop still accepts
   assign wr_ok      = push & (~full | pop);
   assign drop       = push & full & ~pop;
   assign word_data  = word_valid ? mem[rd_ptr][WORD_W-1:0] : '0;
   assign word_last  = word_valid & mem[rd_ptr][WORD_W];

   // ---------------- verdict side ----------------
   state_t                v_state, v_next;
   snap_t                 snap;
   logic [SUM_W-1:0]      rem;
   logic [CONF_WIDTH-1:0] quo;
   logic [DIV_W-1:0]      div_i, qbit;
   logic [DW-1:0]         dsh;
   logic                  div_done, take, discard;

   assign div_done = (div_i == DIV_W'(CONF_WIDTH));
   assign qbit     = DIV_W'(CONF_WIDTH-1) - div_i;
   assign dsh      = DW'(snap.cnt) << qbit;
   assign take     = (DW'(rem) >= dsh);
   assign discard  = close & (v_state != IDLE);

   assign verdict_valid = (v_state == VERDICT);
   assign busy          = (s_state == ACCUM) | (v_state != IDLE);

   // ---------------- next-state logic ----------------
   always_comb begin
      s_next = s_state;
      case (s_state)
         IDLE:    if (in_valid && !close) s_next = ACCUM;
         ACCUM:   if (close) s_next = IDLE;
         default: s_next = IDLE;
      endcase
   end

   always_comb begin
      v_next = v_state;
      case (v_state)
         IDLE:    if (close) v_next = DIVIDE;
         // eight compare/subtract steps, then one cycle to form the verdict
         DIVIDE:  if (div_done) v_next = VERDICT;
         VERDICT: if (verdict_ready) v_next = IDLE;
         default: v_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_state <= IDLE;
         v_state <= IDLE;
      end else begin
         s_state <= s_next;
         v_state <= v_next;
      end
   end

   // ---------------- stream accumulators ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pos      <= '0;
         pack     <= '0;
         bits_acc <= '0;
         sum_acc  <= '0;
         min_acc  <= '1;
         low_acc  <= '0;
         drop_acc <= 1'b0;
      end else if (in_valid) begin
         if (close) begin
            pos      <= '0;
            pack     <= '0;
            bits_acc <= '0;
            sum_acc  <= '0;
            min_acc  <= '1;
            low_acc  <= '0;
            drop_acc <= 1'b0;
         end else begin
            pos      <= pos + POS_W'(1);
            pack     <= push ? '0 : word_nx;
            bits_acc <= bits_nx;
            sum_acc  <= sum_nx;
            min_acc  <= min_nx;
            low_acc  <= low_nx;
            drop_acc <= drop_acc | drop;
         end
      end
   end

   // ---------------- FIFO storage and pointers ----------------
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= {close, word_nx};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fcnt   <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_ok, pop})
            2'b10:   fcnt <= fcnt + (PTR_W+1)'(1);
            2'b01:   fcnt <= fcnt - (PTR_W+1)'(1);
            default: fcnt <= fcnt;
         endcase
      end
   end

   // ---------------- snapshot, divider, verdict registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         snap             <= '0;
         rem              <= '0;
         quo              <= '0;
         div_i            <= '0;
         verdict_escalate <= 1'b0;
         verdict_mean     <= '0;
         verdict_min      <= '0;
         verdict_lowconf  <= '0;
         verdict_bits     <= '0;
      end else begin
         case (v_state)
            IDLE: if (close) begin
               // closing bit's own contribution and drop are included
               snap  <= '{sum: sum_nx, cnt: bits_nx, mn: min_nx, low: low_nx,
                          flag: drop_acc | drop | trunc,
                          mthr: mean_thresh, mlow: max_lowconf};
               rem   <= sum_nx;
               quo   <= '0;
               div_i <= '0;
            end
            DIVIDE: begin
               if (!div_done) begin
                  if (take) begin
                     rem <= rem - dsh[SUM_W-1:0];
                     quo <= quo | (CONF_WIDTH'(1) << qbit);
                  end
                  div_i <= div_i + DIV_W'(1);
               end else begin
                  verdict_escalate <= (quo < snap.mthr) | (snap.low > snap.mlow)
                                      | snap.flag;
                  verdict_mean     <= quo;
                  verdict_min      <= snap.mn;
                  verdict_lowconf  <= snap.low;
                  verdict_bits     <= snap.cnt;
               end
            end
            VERDICT: if (verdict_ready) begin
               verdict_escalate <= 1'b0;
               verdict_mean     <= '0;
               verdict_min      <= '0;
               verdict_lowconf  <= '0;
               verdict_bits     <= '0;
            end
            default: ;
         endcase
      end
   end

   // ---------------- sticky overflow ----------------
   always_ff @(posedge clk) begin
      if (rst)                  overflow <= 1'b0;
      else if (drop || discard) overflow <= 1'b1;
      else if (clear_overflow)  overflow <= 1'b0;
   end

endmodule

// File: tb/tb_kf_choir_verdict.sv
module tb_kf_choir_verdict;
   localparam int HV = 8192, WW = 64, CW = 8, FD = 4, NW = 14;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_bit, in_last;
   logic [CW-1:0] in_conf, conf_thresh, mean_thresh;
   logic [NW-1:0] max_lowconf;
   logic          word_valid, word_ready, word_last;
   logic [WW-1:0] word_data;
   logic          verdict_valid, verdict_ready, verdict_escalate;
   logic [CW-1:0] verdict_mean, verdict_min;
   logic [NW-1:0] verdict_lowconf, verdict_bits;
   logic          overflow, clear_overflow, busy;

   always #5 clk = ~clk;

   kf_choir_verdict #(.HV_DIM(HV), .WORD_W(WW), .CONF_WIDTH(CW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_conf(in_conf),
      .in_last(in_last), .conf_thresh(conf_thresh), .mean_thresh(mean_thresh),
      .max_lowconf(max_lowconf), .word_valid(word_valid), .word_ready(word_ready),
      .word_data(word_data), .word_last(word_last), .verdict_valid(verdict_valid),
      .verdict_ready(verdict_ready), .verdict_escalate(verdict_escalate),
      .verdict_mean(verdict_mean), .verdict_min(verdict_min),
      .verdict_lowconf(verdict_lowconf), .verdict_bits(verdict_bits),
      .overflow(overflow), .clear_overflow(clear_overflow), .busy(busy));

   int checks = 0, errors = 0, words_seen = 0;
   bit rand_ready = 0;

   bit            fb [0:8399];
   logic [CW-1:0] fc [0:8399];
   logic [WW-1:0] exp_w [$];
   bit            exp_l [$];

   typedef struct {bit esc; int mean; int mn; int low; int bits;} verd_t;
   typedef struct {int len; int ca; int cb; int ct; int mt; int ml;
                   bit esc; int mean; int mn; int low;} vec_t;
   vec_t tbl [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // expected word stream: bit k of the frame -> word k/64, bit k%64
   function automatic void model_words(int off, int n, int keep);
      int nw = (n + 63) / 64;
      for (int w = 0; w < nw; w++) begin
         logic [WW-1:0] d = '0;
         for (int j = 0; j < 64; j++)
            if (64*w + j < n) d[j] = fb[off + 64*w + j];
         if (w < keep) begin
            exp_w.push_back(d);
            exp_l.push_back(w == nw - 1);
         end
      end
   endfunction

   function automatic verd_t model_verdict(int off, int n, int ct, int mt, int ml, bit forced);
      verd_t r;
      longint sum = 0;
      int mn = 255, low = 0;
      for (int k = 0; k < n; k++) begin
         sum += fc[off+k];
         if (fc[off+k] < mn) mn = fc[off+k];
         if (fc[off+k] < ct) low++;
      end
      r.mean = int'(sum / n);
      r.mn   = mn;
      r.low  = low;
      r.bits = n;
      r.esc  = (r.mean < mt) || (low > ml) || forced;
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst && word_valid && word_ready) begin
         words_seen++;
         if (exp_w.size() == 0) begin
            checks++; errors++;
            $display("FAIL word_unexpected actual=%0h required=none", word_data);
         end else begin
            chk("word_data", word_data, exp_w.pop_front());
            chk("word_last", word_last, exp_l.pop_front());
         end
      end
   end

   task automatic set_thr(input int ct, input int mt, input int ml);
      conf_thresh = CW'(ct); mean_thresh = CW'(mt); max_lowconf = NW'(ml);
   endtask

   task automatic send_frame(input int off, input int n, input bit use_last, input int gap_pct);
      for (int k = 0; k < n; k++) begin
         if (rand_ready) word_ready = ($urandom_range(3) != 0);
         in_valid = 1'b1; in_bit = fb[off+k]; in_conf = fc[off+k];
         in_last  = use_last && (k == n - 1);
         @(posedge clk); #1;
         in_valid = 1'b0; in_last = 1'b0;
         if (k != n - 1 && gap_pct > 0 && $urandom_range(99) < gap_pct)
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic wait_valid(input string tag);
      int t = 0;
      while (!verdict_valid && t < 400) begin
         if (rand_ready) word_ready = ($urandom_range(3) != 0);
         @(posedge clk); #1; t++;
      end
      chk({tag, "_verdict_arrived"}, verdict_valid, 1'b1);
   endtask

   task automatic check_fields(input verd_t e, input string tag);
      chk({tag, "_esc"},  verdict_escalate, e.esc);
      chk({tag, "_mean"}, verdict_mean, e.mean);
      chk({tag, "_min"},  verdict_min, e.mn);
      chk({tag, "_low"},  verdict_lowconf, e.low);
      chk({tag, "_bits"}, verdict_bits, e.bits);
   endtask

   task automatic accept(input string tag);
      verdict_ready = 1'b1;
      @(posedge clk); #1;
      verdict_ready = 1'b0;
      chk({tag, "_valid_clr"}, verdict_valid, 1'b0);
      chk({tag, "_bits_clr"},  verdict_bits, 0);
   endtask

   task automatic drain(input string tag);
      int t = 0;
      word_ready = 1'b1;
      while (exp_w.size() != 0 && t < 300) begin @(posedge clk); #1; t++; end
      repeat (2) @(posedge clk); #1;
      chk({tag, "_words_left"}, exp_w.size(), 0);
      chk({tag, "_fifo_empty"}, word_valid, 1'b0);
   endtask

   initial begin
      verd_t e;
      int ws;
      tbl[0] = '{4,  10,  20,  15,  10,  5,  0, 15,  10,  2};
      tbl[1] = '{5,  100, 0,   50,  50,  1,  1, 60,  0,   2};
      tbl[2] = '{3,  255, 254, 255, 255, 3,  1, 254, 254, 1};
      tbl[3] = '{1,  7,   9,   0,   7,   0,  0, 7,   7,   0};
      tbl[4] = '{64, 0,   1,   1,   1,   32, 1, 0,   0,   32};
      tbl[5] = '{65, 128, 128, 128, 128, 0,  0, 128, 128, 0};

      rst = 1'b1; in_valid = 0; in_bit = 0; in_conf = '0; in_last = 0;
      set_thr(0, 0, 0); word_ready = 1'b1; verdict_ready = 0; clear_overflow = 0;
      repeat (3) @(posedge clk); #1;
      chk("rst_word_valid", word_valid, 0);
      chk("rst_word_data", word_data, 0);
      chk("rst_verdict_valid", verdict_valid, 0);
      chk("rst_verdict_bits", verdict_bits, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // table of short frames, confidences alternating ca/cb
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < tbl[i].len; k++) begin
            fb[k] = 1'($urandom);
            fc[k] = CW'((k % 2 == 0) ? tbl[i].ca : tbl[i].cb);
         end
         set_thr(tbl[i].ct, tbl[i].mt, tbl[i].ml);
         model_words(0, tbl[i].len, 1000);
         send_frame(0, tbl[i].len, 1, 0);
         e = '{tbl[i].esc, tbl[i].mean, tbl[i].mn, tbl[i].low, tbl[i].len};
         wait_valid($sformatf("tbl%0d", i));
         check_fields(e, $sformatf("tbl%0d", i));
         accept($sformatf("tbl%0d", i));
      end
      drain("tbl");

      // full 8192-bit frame, exact verdict latency
      for (int k = 0; k < HV; k++) begin fb[k] = 1'($urandom); fc[k] = 8'd255; end
      set_thr(64, 128, 0);
      ws = words_seen;
      model_words(0, HV, 1000);
      send_frame(0, HV, 1, 0);
      chk("t1_busy", busy, 1'b1);
      repeat (8) @(posedge clk); #1;
      chk("t1_valid_at_8", verdict_valid, 1'b0);
      @(posedge clk); #1;
      chk("t1_valid_at_9", verdict_valid, 1'b1);
      check_fields('{0, 255, 255, 0, 8192}, "t1");
      accept("t1");
      drain("t1");
      chk("t1_word_count", words_seen - ws, 128);

      // 100-bit 0xA5 pattern, confidence 0/200
      for (int k = 0; k < 100; k++) begin
         fb[k] = ((8'hA5 >> (k % 8)) & 8'h1) != 0;
         fc[k] = (k % 2 == 0) ? 8'd0 : 8'd200;
      end
      set_thr(64, 128, 10);
      model_words(0, 100, 1000);
      send_frame(0, 100, 1, 0);
      wait_valid("t2");
      check_fields('{1, 100, 0, 50, 100}, "t2");
      accept("t2");
      drain("t2");

      // 320 bits with the consumer stalled: fifth word dropped
      for (int k = 0; k < 320; k++) begin fb[k] = 1'($urandom); fc[k] = 8'd200; end
      set_thr(64, 128, 0);
      word_ready = 1'b0;
      model_words(0, 320, 4);
      send_frame(0, 320, 1, 0);
      chk("t3_overflow", overflow, 1'b1);
      wait_valid("t3");
      check_fields('{1, 200, 200, 0, 320}, "t3");
      accept("t3");
      drain("t3");
      clear_overflow = 1'b1; @(posedge clk); #1; clear_overflow = 1'b0;
      chk("t3_overflow_clr", overflow, 1'b0);

      // two 16-bit frames back-to-back, verdict held
      for (int k = 0; k < 32; k++) begin fb[k] = 1'($urandom); fc[k] = CW'($urandom); end
      set_thr(100, 90, 8);
      model_words(0, 16, 1000);
      model_words(16, 16, 1000);
      send_frame(0, 16, 1, 0);
      send_frame(16, 16, 1, 0);
      chk("t4_overflow", overflow, 1'b1);
      e = model_verdict(0, 16, 100, 90, 8, 0);
      wait_valid("t4");
      check_fields(e, "t4");
      repeat (20) @(posedge clk); #1;
      chk("t4_held_valid", verdict_valid, 1'b1);
      check_fields(e, "t4_held");
      accept("t4");
      repeat (20) @(posedge clk); #1;
      chk("t4_second_discarded", verdict_valid, 1'b0);
      chk("t4_idle", busy, 1'b0);
      drain("t4");

      // reset mid-frame with a queued word and pending verdict
      for (int k = 0; k < 300; k++) begin fb[k] = 1'($urandom); fc[k] = CW'($urandom); end
      word_ready = 1'b0;
      send_frame(0, 16, 1, 0);
      send_frame(16, 30, 0, 0);
      chk("t6_pre_busy", busy, 1'b1);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      chk("t6_word_valid", word_valid, 0);
      chk("t6_word_data", word_data, 0);
      chk("t6_verdict_valid", verdict_valid, 0);
      chk("t6_overflow", overflow, 0);
      chk("t6_busy", busy, 0);
      exp_w.delete(); exp_l.delete();
      word_ready = 1'b1;
      set_thr(50, 20, 64);
      ws = words_seen;
      model_words(200, 64, 1000);
      send_frame(200, 64, 1, 0);
      wait_valid("t6");
      check_fields(model_verdict(200, 64, 50, 20, 64, 0), "t6");
      accept("t6");
      drain("t6");
      chk("t6_word_count", words_seen - ws, 1);

      // force-close at 8192 bits, then a 1-bit frame
      for (int k = 0; k <= HV; k++) begin fb[k] = 1'($urandom); fc[k] = CW'($urandom_range(100, 255)); end
      set_thr(10, 10, 100);
      model_words(0, HV, 1000);
      send_frame(0, HV, 0, 0);
      wait_valid("t5");
      check_fields(model_verdict(0, HV, 10, 10, 100, 1), "t5");
      chk("t5_truncated_esc", verdict_escalate, 1'b1);
      accept("t5");
      model_words(HV, 1, 1000);
      send_frame(HV, 1, 1, 0);
      wait_valid("t5b");
      check_fields(model_verdict(HV, 1, 10, 10, 100, 0), "t5b");
      accept("t5b");
      drain("t5");

      // randomized frames against the reference model
      rand_ready = 1;
      for (int f = 0; f < 25; f++) begin
         int n, ct, mt, ml;
         n  = $urandom_range(1, 200);
         ct = $urandom_range(255); mt = $urandom_range(255); ml = $urandom_range(n);
         for (int k = 0; k < n; k++) begin fb[k] = 1'($urandom); fc[k] = CW'($urandom); end
         set_thr(ct, mt, ml);
         model_words(0, n, 1000);
         send_frame(0, n, 1, 20);
         wait_valid($sformatf("rnd%0d", f));
         check_fields(model_verdict(0, n, ct, mt, ml, 0), $sformatf("rnd%0d", f));
         accept($sformatf("rnd%0d", f));
      end
      rand_ready = 0;
      drain("rnd");
      chk("rnd_overflow", overflow, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/kf_choir_verdict.md
Name: kf_choir_verdict

Overview:
Sits directly downstream of the ensemble choir and consumes its bit-serial consensus stream (bit, per-bit confidence, last). It packs result bits into 64-bit words for host/DMA readout through a small FIFO. It also accumulates per-frame confidence statistics and issues one verdict per hypervector frame: auto-act or escalate to human/bigger model.

Parameters:
HV_DIM, 8192, maximum bits per frame; a frame is force-closed at this count
WORD_W, 64, packed output word width
CONF_WIDTH, 8, confidence width (0 = split, 255 = unanimous)
FIFO_DEPTH, 4, output word FIFO depth (power of 2, >= 2)
CNT_W, $clog2(HV_DIM+1), bit and low-confidence counter width
SUM_W, CONF_WIDTH+CNT_W, confidence sum width

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  stream bit valid; no backpressure, accepted every asserted cycle
in_bit  in  1  consensus result bit
in_conf  in  CONF_WIDTH  confidence of this bit
in_last  in  1  last bit of frame; qualified by in_valid
conf_thresh  in  CONF_WIDTH  a bit is low-confidence when in_conf < conf_thresh
mean_thresh  in  CONF_WIDTH  escalate when mean confidence < mean_thresh
max_lowconf  in  CNT_W  escalate when lowconf count > max_lowconf
word_valid  out  1  FIFO head valid
word_ready  in  1  consumer accepts head
word_data  out  WORD_W  packed bits, LSB = earliest bit
word_last  out  1  head word closes a frame
verdict_valid  out  1  verdict pending
verdict_ready  in  1  verdict accepted
verdict_escalate  out  1  1 = escalate, 0 = auto-act
verdict_mean  out  CONF_WIDTH  floor(sum/count)
verdict_min  out  CONF_WIDTH  minimum in_conf in frame
verdict_lowconf  out  CNT_W  count of low-confidence bits
verdict_bits  out  CNT_W  bits in frame
overflow  out  1  sticky; set on any dropped word or verdict
clear_overflow  in  1  clears overflow; a simultaneous set wins
busy  out  1  frame in progress or verdict not yet accepted

Behaviour:
- Reset: all outputs 0; FIFO empty; accumulators cleared; FSM in IDLE. Reset mid-frame discards the partial frame, queued words and pending verdict. The next in_bit lands in word bit 0.
- Packing: stream bit k goes to word bit k mod 64. A word is pushed when bit 63 is filled, on in_last, or on force-close. A partial final word is zero-padded above the last bit. word_last is set on the frame's final word.
- FIFO: push is registered; word_valid rises at the earliest 1 cycle after the push edge. Pop occurs when word_valid && word_ready. Push while full drops the word, sets overflow, and marks the frame dropped. Push and pop in the same cycle while full succeeds.
- Stats per frame:
  - sum += in_conf (SUM_W, cannot overflow)
  - min starts at all-ones
  - lowconf++ when in_conf < conf_thresh
  - bits++
- Force-close: when bits reaches HV_DIM without in_last, that bit is treated as last and the frame is marked truncated.
- FSM states: IDLE, ACCUM, DIVIDE, VERDICT.
  - IDLE -> ACCUM on in_valid.
  - On the closing bit, snapshot sum, count, min, lowconf and flags into the verdict registers, then clear the accumulators. The next frame may begin the very next cycle, and the stream side returns to IDLE/ACCUM independently.
  - DIVIDE: restoring division, 8 cycles, quotient bit i = 7..0: if rem >= count<<i then rem -= count<<i and q[i] = 1. The quotient fits in CONF_WIDTH because sum < 256*count.
  - VERDICT: verdict_valid is first high 9 cycles after the cycle in which the closing bit is sampled. Verdict outputs are held stable until verdict_ready, then clear on the next edge.
- escalate = (mean < mean_thresh) | (lowconf > max_lowconf) | dropped | truncated.
- If a frame closes while the previous verdict is still in DIVIDE/VERDICT, the new verdict is discarded, overflow is set, and its words still flow.
- Thresholds are sampled at the closing bit.
- busy = ACCUM | DIVIDE | VERDICT.

Test Plan:
- 8192 bits, conf = 255, mean_thresh = 128, conf_thresh = 64, word_ready = 1 -> 128 words, word_last on word 127 only; verdict escalate = 0, mean = 255, min = 255, lowconf = 0, bits = 8192; verdict_valid asserted 9 cycles after in_last.
- 100-bit frame, conf alternating 0/200, bits = 0xA5 pattern -> 2 words; word0 LSB-first pattern; word1 bits [63:36] = 0 with word_last; mean = 100, min = 0, lowconf = 50, escalate = 1.
- word_ready = 0 across a 320-bit frame, depth 4 -> 5th word dropped, overflow = 1, escalate = 1; clear_overflow -> overflow = 0.
- Two 16-bit frames back-to-back with verdict_ready = 0 -> first verdict held stable, second discarded, overflow = 1, 2 words both with word_last.
- 8193 bits without in_last -> force-close at bit 8192, escalate = 1; bit 8193 starts a new frame with bits = 1.
- rst pulse at bit 30 of a frame -> all outputs 0 on the next cycle; a new 64-bit frame yields exactly one word matching the input, with word_last set.
